branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Execute-side counterpart of the fetch-stage branch predictor.
- Records each prediction the predictor makes at fetch in an in-order in-flight queue.
- When execute resolves a branch, compares the actual outcome with the oldest recorded prediction.
- Drives the predictor's update interface (BRANCHFLAG, branch_addr, branch_taken, branch_target) and, on a mispredict, issues a PC redirect and a multi-cycle pipeline flush.

Parameters:
- DEPTH, 4, in-flight queue entries (power of 2, 2..16).
- FLUSH_CYCLES, 2, cycles flush is held after a mispredict (>=1).
- CNT_W, 16, statistics counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- fetch_valid  input  1  a branch was fetched with a prediction this cycle.
- fetch_pc  input  32  PC of the fetched branch.
- fetch_pred_taken  input  1  predicted direction.
- fetch_pred_addr  input  32  predicted target.
- q_full  output  1  queue full; fetch must stall branches.
- ex_valid  input  1  execute resolved the oldest in-flight branch.
- ex_taken  input  1  actual direction.
- ex_target  input  32  actual target.
- BRANCHFLAG  output  1  one-cycle predictor update strobe.
- branch_addr  output  32  PC of the resolved branch.
- branch_taken  output  1  actual direction.
- branch_target  output  32  actual target.
- redirect_valid  output  1  one-cycle fetch redirect strobe.
- redirect_pc  output  32  corrected fetch PC.
- flush  output  1  kill younger pipeline stages.
- err_overflow  output  1  sticky: push while full.
- err_underflow  output  1  sticky: ex_valid while queue empty.
- branch_count  output  CNT_W  resolved branches.
- mispredict_count  output  CNT_W  mispredicts.

Behaviour:
- Reset (asynchronous, reset=0): all outputs 0, queue empty (read/write pointers 0, count 0), FSM in RUN.

Queue:
- Circular buffer of {pc, pred_taken, pred_addr}. Push on fetch_valid, pop on ex_valid (head = oldest entry).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. q_full = (count==DEPTH), combinational from count.
- Push while full without a simultaneous pop: entry dropped, err_overflow set.
- Push and pop in the same cycle: both happen, including when full; count unchanged.
- ex_valid while empty: no pop, no update strobe, err_underflow set.
- Error flags are sticky; only reset clears them.

Resolution (RUN state, ex_valid with queue non-empty):
- mispredict = (head.pred_taken != ex_taken) OR (ex_taken AND head.pred_addr != ex_target).
- One cycle later, registered outputs:
  - BRANCHFLAG=1 for one cycle, for correct and incorrect predictions alike.
  - branch_addr = head.pc, branch_taken = ex_taken, branch_target = ex_target.
  - branch_target holds ex_target even when ex_taken=0.
  - All update fields hold their values until the next strobe.
- On mispredict, also one cycle later:
  - redirect_valid=1 for one cycle.
  - redirect_pc = ex_target if ex_taken, else head.pc+4 (32-bit wrap).
  - flush=1 for exactly FLUSH_CYCLES cycles.
  - Queue cleared (all younger entries are wrong-path). A push in the same cycle is discarded and does not set err_overflow.
- FSM goes RUN -> FLUSH.

FSM:
- RUN: normal operation as above.
- FLUSH: a down-counter is loaded with FLUSH_CYCLES-1. fetch_valid and ex_valid are ignored: no push, no pop, no error flags. When the counter reaches 0, flush deasserts and the FSM returns to RUN on the next cycle.
- No mispredict can be detected inside FLUSH.
- Reset asserted mid-flush: immediate return to RUN with flush=0 and the queue empty.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: branch_count increments on every accepted resolution; mispredict_count increments on each mispredict. Both saturate at all-ones and reset to 0.
- Undefined: both outputs tied to 0 and no counter registers are synthesized. All other behaviour is identical.

Test Plan:
- Correct not-taken: push pc=0x100, pred 0/0x0; ex_valid taken=0, target=0x0 -> next cycle BRANCHFLAG=1, branch_addr=0x100, branch_taken=0; redirect_valid=0, flush=0.
- Direction mispredict: push pc=0x200, pred 0, plus a younger push pc=0x204; resolve taken=1, target=0x280 -> redirect_pc=0x280, flush high 2 cycles, queue empty afterwards, mispredict_count=1.
- Target mispredict: push pc=0x300, pred 1/0x340; resolve taken=1, target=0x380 -> redirect_pc=0x380; BRANCHFLAG with branch_target=0x380.
- Not-taken mispredict: push pc=0xFFFFFFFC, pred 1; resolve taken=0 -> redirect_pc=0x00000000 (wrap).
- Full/empty: 4 pushes -> q_full=1; 5th push alone -> err_overflow=1, count stays 4; push+pop together when full -> accepted, q_full stays 1; 4 further pops -> empty; one extra ex_valid -> err_underflow=1, no BRANCHFLAG.
- Flush and reset: during FLUSH drive fetch_valid/ex_valid -> ignored, no error flags; reset=0 mid-flush -> flush=0 immediately, q_full=0, counters 0.

Source files
------------

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - execute-side branch resolution, predictor update, redirect and flush
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolver #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_pred_taken,
  input  logic [31:0]      fetch_pred_addr,
  output logic             q_full,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             BRANCHFLAG,
  output logic [31:0]      branch_addr,
  output logic             branch_taken,
  output logic [31:0]      branch_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;

  logic [31:0]     pc_mem_q   [DEPTH];
  logic [31:0]     pc_mem_d   [DEPTH];
  logic            pt_mem_q   [DEPTH];
  logic            pt_mem_d   [DEPTH];
  logic [31:0]     pa_mem_q   [DEPTH];
  logic [31:0]     pa_mem_d   [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  logic            branchflag_q, branchflag_d;
  logic [31:0]     branch_addr_q, branch_addr_d;
  logic            branch_taken_q, branch_taken_d;
  logic [31:0]     branch_target_q, branch_target_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic            flush_q, flush_d;
  logic            err_overflow_q, err_overflow_d;
  logic            err_underflow_q, err_underflow_d;

  logic [31:0]     head_pc;
  logic            head_pred_taken;
  logic [31:0]     head_pred_addr;
  logic            q_empty;
  logic            full;
  logic            do_push;
  logic            do_pop;
  logic            mispredict;

  assign head_pc         = pc_mem_q[rd_ptr_q];
  assign head_pred_taken = pt_mem_q[rd_ptr_q];
  assign head_pred_addr  = pa_mem_q[rd_ptr_q];
  assign q_empty         = (count_q == '0);
  assign full            = (count_q == (AW+1)'(DEPTH));

  // Queue bookkeeping, resolution compare, error flags and the RUN/FLUSH FSM.
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    pc_mem_d         = pc_mem_q;
    pt_mem_d         = pt_mem_q;
    pa_mem_d         = pa_mem_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    branchflag_d     = 1'b0;
    branch_addr_d    = branch_addr_q;
    branch_taken_d   = branch_taken_q;
    branch_target_d  = branch_target_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    err_overflow_d   = err_overflow_q;
    err_underflow_d  = err_underflow_q;
    do_push          = 1'b0;
    do_pop           = 1'b0;
    mispredict       = 1'b0;

    case (state_q)
      ST_RUN: begin
        do_pop     = ex_valid && !q_empty;
        mispredict = do_pop && ((head_pred_taken != ex_taken) ||
                                (ex_taken && (head_pred_addr != ex_target)));
        // A pop frees the slot the push needs, so push+pop is fine when full.
        do_push    = fetch_valid && (!full || do_pop) && !mispredict;

        if (ex_valid && q_empty) begin
          err_underflow_d = 1'b1;
        end
        if (fetch_valid && full && !do_pop) begin
          err_overflow_d = 1'b1;
        end

        if (do_pop) begin
          branchflag_d    = 1'b1;
          branch_addr_d   = head_pc;
          branch_taken_d  = ex_taken;
          branch_target_d = ex_target;
        end

        if (mispredict) begin
          // Everything younger than the head is wrong-path: drop the whole queue.
          redirect_valid_d = 1'b1;
          redirect_pc_d    = ex_taken ? ex_target : (head_pc + 32'd4);
          flush_d          = 1'b1;
          flush_cnt_d      = FW'(FLUSH_CYCLES - 1);
          state_d          = ST_FLUSH;
          wr_ptr_d         = '0;
          rd_ptr_d         = '0;
          count_d          = '0;
        end else begin
          if (do_push) begin
            pc_mem_d[wr_ptr_q] = fetch_pc;
            pt_mem_d[wr_ptr_q] = fetch_pred_taken;
            pa_mem_d[wr_ptr_q] = fetch_pred_addr;
            wr_ptr_d           = wr_ptr_q + AW'(1);
          end
          if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
          if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
          end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
          end
        end
      end

      ST_FLUSH: begin
        // Inputs are ignored here; flush stays high until the counter expires.
        if (flush_cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FW'(1);
        end
      end

      default: begin
        state_d = ST_RUN;
        flush_d = 1'b0;
      end
    endcase
  end

  // State, queue storage and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_RUN;
      flush_cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i] <= '0;
        pt_mem_q[i] <= 1'b0;
        pa_mem_q[i] <= '0;
      end
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      branchflag_q     <= 1'b0;
      branch_addr_q    <= '0;
      branch_taken_q   <= 1'b0;
      branch_target_q  <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      err_overflow_q   <= 1'b0;
      err_underflow_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      pc_mem_q         <= pc_mem_d;
      pt_mem_q         <= pt_mem_d;
      pa_mem_q         <= pa_mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      branchflag_q     <= branchflag_d;
      branch_addr_q    <= branch_addr_d;
      branch_taken_q   <= branch_taken_d;
      branch_target_q  <= branch_target_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      err_overflow_q   <= err_overflow_d;
      err_underflow_q  <= err_underflow_d;
    end
  end

  assign q_full         = full;
  assign BRANCHFLAG     = branchflag_q;
  assign branch_addr    = branch_addr_q;
  assign branch_taken   = branch_taken_q;
  assign branch_target  = branch_target_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign err_overflow   = err_overflow_q;
  assign err_underflow  = err_underflow_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  // Saturating resolution and mispredict counters.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (do_pop && (branch_count_q != '1)) begin
      branch_count_d = branch_count_q + CNT_W'(1);
    end
    if (mispredict && (mispredict_count_q != '1)) begin
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - table-driven self-checking bench for branch_resolver
module tb_branch_resolver;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_pred_taken;
  logic [31:0] fetch_pred_addr;
  logic        q_full;
  logic        ex_valid;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        BRANCHFLAG;
  logic [31:0] branch_addr;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        err_overflow;
  logic        err_underflow;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  branch_resolver dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .fetch_pred_taken (fetch_pred_taken),
    .fetch_pred_addr  (fetch_pred_addr),
    .q_full           (q_full),
    .ex_valid         (ex_valid),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .BRANCHFLAG       (BRANCHFLAG),
    .branch_addr      (branch_addr),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .err_overflow     (err_overflow),
    .err_underflow    (err_underflow),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        fpt;
    logic [31:0] fpa;
    logic        ev;
    logic        et;
    logic [31:0] etg;
    logic        bf;
    logic [31:0] ba;
    logic        bt;
    logic [31:0] btg;
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
    logic        qf;
    logic        eo;
    logic        eu;
    int          bc;
    int          mc;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(
    input logic fv, input logic [31:0] fpc, input logic fpt, input logic [31:0] fpa,
    input logic ev, input logic et, input logic [31:0] etg,
    input logic bf, input logic [31:0] ba, input logic bt, input logic [31:0] btg,
    input logic rv, input logic [31:0] rpc, input logic fl, input logic qf,
    input logic eo, input logic eu, input int bc, input int mc);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.fpt = fpt; v.fpa = fpa;
    v.ev = ev; v.et = et; v.etg = etg;
    v.bf = bf; v.ba = ba; v.bt = bt; v.btg = btg;
    v.rv = rv; v.rpc = rpc; v.fl = fl; v.qf = qf;
    v.eo = eo; v.eu = eu; v.bc = bc; v.mc = mc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] fpc, input logic fpt,
                       input logic [31:0] fpa, input logic ev, input logic et,
                       input logic [31:0] etg);
    fetch_valid      = fv;
    fetch_pc         = fpc;
    fetch_pred_taken = fpt;
    fetch_pred_addr  = fpa;
    ex_valid         = ev;
    ex_taken         = et;
    ex_target        = etg;
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, " BRANCHFLAG"}, 32'(BRANCHFLAG), 32'd0);
    chk({tag, " branch_addr"}, branch_addr, 32'd0);
    chk({tag, " redirect_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, " flush"}, 32'(flush), 32'd0);
    chk({tag, " q_full"}, 32'(q_full), 32'd0);
    chk({tag, " err_overflow"}, 32'(err_overflow), 32'd0);
    chk({tag, " err_underflow"}, 32'(err_underflow), 32'd0);
    chk({tag, " branch_count"}, 32'(branch_count), 32'd0);
    chk({tag, " mispredict_count"}, 32'(mispredict_count), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          fv fpc           fpt fpa           ev et etg            bf ba            bt btg           rv rpc  fl qf eo eu bc mc
    // correct not-taken
    vecs.push_back(mk(1, 32'h100,      0, 32'h0,    0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0,        0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        0, 0,        0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    0, 0, 32'h0,        0, 32'h100,      0, 32'h0,        0, 0,        0, 0, 0, 0, 1, 0));
    // direction mispredict with younger entries and a same-cycle push
    vecs.push_back(mk(1, 32'h200,      0, 32'h0,    0, 0, 32'h0,        0, 32'h100,      0, 32'h0,        0, 0,        0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 32'h204,      0, 32'h0,    0, 0, 32'h0,        0, 32'h100,      0, 32'h0,        0, 0,        0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 32'h208,      0, 32'h0,    1, 1, 32'h280,      1, 32'h200,      1, 32'h280,      1, 32'h280,  1, 0, 0, 0, 2, 1));
    // inputs during flush are ignored
    vecs.push_back(mk(1, 32'h20C,      0, 32'h0,    1, 0, 32'h0,        0, 32'h200,      1, 32'h280,      0, 0,        1, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 32'h210,      0, 32'h0,    1, 1, 32'h0,        0, 32'h200,      1, 32'h280,      0, 0,        0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    0, 0, 32'h0,        0, 32'h200,      1, 32'h280,      0, 0,        0, 0, 0, 0, 2, 1));
    // target mispredict; head must be 0x300, proving the queue was cleared
    vecs.push_back(mk(1, 32'h300,      1, 32'h340,  0, 0, 32'h0,        0, 32'h200,      1, 32'h280,      0, 0,        0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    1, 1, 32'h380,      1, 32'h300,      1, 32'h380,      1, 32'h380,  1, 0, 0, 0, 3, 2));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    0, 0, 32'h0,        0, 32'h300,      1, 32'h380,      0, 0,        1, 0, 0, 0, 3, 2));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    0, 0, 32'h0,        0, 32'h300,      1, 32'h380,      0, 0,        0, 0, 0, 0, 3, 2));
    // not-taken mispredict with pc+4 wrap
    vecs.push_back(mk(1, 32'hFFFFFFFC, 1, 32'h1000, 0, 0, 32'h0,        0, 32'h300,      1, 32'h380,      0, 0,        0, 0, 0, 0, 3, 2));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    1, 0, 32'h12345678, 1, 32'hFFFFFFFC, 0, 32'h12345678, 1, 32'h0,    1, 0, 0, 0, 4, 3));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h12345678, 0, 0,        1, 0, 0, 0, 4, 3));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h12345678, 0, 0,        0, 0, 0, 0, 4, 3));
    // fill to full, overflow, push+pop when full
    vecs.push_back(mk(1, 32'h400,      0, 32'h0,    0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h12345678, 0, 0,        0, 0, 0, 0, 4, 3));
    vecs.push_back(mk(1, 32'h404,      0, 32'h0,    0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h12345678, 0, 0,        0, 0, 0, 0, 4, 3));
    vecs.push_back(mk(1, 32'h408,      0, 32'h0,    0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h12345678, 0, 0,        0, 0, 0, 0, 4, 3));
    vecs.push_back(mk(1, 32'h40C,      0, 32'h0,    0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h12345678, 0, 0,        0, 1, 0, 0, 4, 3));
    vecs.push_back(mk(1, 32'h410,      0, 32'h0,    0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h12345678, 0, 0,        0, 1, 1, 0, 4, 3));
    vecs.push_back(mk(1, 32'h414,      0, 32'h0,    1, 0, 32'h0,        1, 32'h400,      0, 32'h0,        0, 0,        0, 1, 1, 0, 5, 3));
    // drain, then underflow
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    1, 0, 32'h0,        1, 32'h404,      0, 32'h0,        0, 0,        0, 0, 1, 0, 6, 3));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    1, 0, 32'h0,        1, 32'h408,      0, 32'h0,        0, 0,        0, 0, 1, 0, 7, 3));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    1, 0, 32'h0,        1, 32'h40C,      0, 32'h0,        0, 0,        0, 0, 1, 0, 8, 3));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    1, 0, 32'h0,        1, 32'h414,      0, 32'h0,        0, 0,        0, 0, 1, 0, 9, 3));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    1, 0, 32'h0,        0, 32'h414,      0, 32'h0,        0, 0,        0, 0, 1, 1, 9, 3));
    // correct taken prediction
    vecs.push_back(mk(1, 32'h500,      1, 32'h600,  0, 0, 32'h0,        0, 32'h414,      0, 32'h0,        0, 0,        0, 0, 1, 1, 9, 3));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    1, 1, 32'h600,      1, 32'h500,      1, 32'h600,      0, 0,        0, 0, 1, 1, 10, 3));
    // mispredict that the reset sequence below interrupts
    vecs.push_back(mk(1, 32'h700,      0, 32'h0,    0, 0, 32'h0,        0, 32'h500,      1, 32'h600,      0, 0,        0, 0, 1, 1, 10, 3));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,    1, 1, 32'h720,      1, 32'h700,      1, 32'h720,      1, 32'h720,  1, 0, 1, 1, 11, 4));

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_idle_state("reset");
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].fv, vecs[i].fpc, vecs[i].fpt, vecs[i].fpa,
            vecs[i].ev, vecs[i].et, vecs[i].etg);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d BRANCHFLAG", i), 32'(BRANCHFLAG), 32'(vecs[i].bf));
      chk($sformatf("v%0d branch_addr", i), branch_addr, vecs[i].ba);
      chk($sformatf("v%0d branch_taken", i), 32'(branch_taken), 32'(vecs[i].bt));
      chk($sformatf("v%0d branch_target", i), branch_target, vecs[i].btg);
      chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].rv));
      if (vecs[i].rv) begin
        chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
      end
      chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].fl));
      chk($sformatf("v%0d q_full", i), 32'(q_full), 32'(vecs[i].qf));
      chk($sformatf("v%0d err_overflow", i), 32'(err_overflow), 32'(vecs[i].eo));
      chk($sformatf("v%0d err_underflow", i), 32'(err_underflow), 32'(vecs[i].eu));
      chk($sformatf("v%0d branch_count", i), 32'(branch_count), STATS ? 32'(vecs[i].bc) : 32'd0);
      chk($sformatf("v%0d mispredict_count", i), 32'(mispredict_count), STATS ? 32'(vecs[i].mc) : 32'd0);
    end

    // Reset asserted mid-flush acts immediately, without a clock edge.
    drive(1, 32'h800, 0, 0, 1, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_idle_state("midflush_reset");

    // After release the queue is empty: a lone ex_valid must underflow.
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_state("post_reset");
    drive(0, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("post_reset underflow", 32'(err_underflow), 32'd1);
    chk("post_reset no strobe", 32'(BRANCHFLAG), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
